// File: rtl/data_sram_resp.sv
// Memory-side responder for the core's data SRAM port: word RAM plus MMIO config registers.
// Define CONF_TIMER_EN to build the free-running TIMER register at offset 16'hf030.
module data_sram_resp #(
  parameter int          RAM_AW    = 16,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
  parameter logic [31:0] CONF_MASK = 32'hffff_0000,
  parameter logic [31:0] SIMU_VAL  = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_NUM    = 16'hf010;
  localparam logic [15:0] OFF_SWITCH = 16'hf020;
  localparam logic [15:0] OFF_TIMER  = 16'hf030;
  localparam logic [15:0] OFF_SIMU   = 16'hf040;
  localparam logic [15:0] OFF_IOSIMU = 16'hf050;

  function automatic logic [31:0] byte_merge(input logic [31:0] nv, input logic [31:0] ov,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = ov;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[8*k +: 8] = nv[8*k +: 8];
    return r;
  endfunction

  logic [31:0]       mem_q [0:(1<<RAM_AW)-1];
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       num_q, num_d;
  logic [31:0]       io_q, io_d;
  logic [15:0]       led_q, led_d;
  logic [7:0]        sw_meta_q, sw_sync_q;
  logic [31:0]       conf_rd, ram_rd, timer_rd;
  logic              is_conf, conf_wr;
  logic [15:0]       off;
  logic [RAM_AW-1:0] ram_idx;

  assign is_conf = (data_sram_addr & CONF_MASK) == CONF_BASE;
  assign off     = {data_sram_addr[15:2], 2'b00};
  assign ram_idx = data_sram_addr[RAM_AW+1:2];
  assign conf_wr = data_sram_en && is_conf && (data_sram_we != 4'h0);
  assign ram_rd  = mem_q[ram_idx];

`ifdef CONF_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A software write replaces this cycle's increment; counting resumes next cycle.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (conf_wr && off == OFF_TIMER)
      timer_d = byte_merge(data_sram_wdata, timer_q, data_sram_we);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_q <= 32'h0;
    else         timer_q <= timer_d;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = 32'h0;
`endif

  always_comb begin
    conf_rd = 32'h0;
    case (off)
      OFF_LED:    conf_rd = {16'h0, led_q};
      OFF_NUM:    conf_rd = num_q;
      OFF_SWITCH: conf_rd = {24'h0, sw_sync_q};
      OFF_TIMER:  conf_rd = timer_rd;
      OFF_SIMU:   conf_rd = SIMU_VAL;
      OFF_IOSIMU: conf_rd = io_q;
      default:    conf_rd = 32'h0;
    endcase

    led_d = led_q;
    num_d = num_q;
    io_d  = io_q;
    if (conf_wr) begin
      case (off)
        OFF_LED: begin
          if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
          if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        OFF_NUM:    num_d = byte_merge(data_sram_wdata, num_q, data_sram_we);
        OFF_IOSIMU: if (data_sram_we == 4'hf) io_d = {data_sram_wdata[15:0], data_sram_wdata[31:16]};
        default: ;
      endcase
    end

    // Read-first: both paths sample the location before this cycle's write lands.
    rdata_d = rdata_q;
    if (data_sram_en) rdata_d = is_conf ? conf_rd : ram_rd;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'hffff;
      num_q     <= 32'h0;
      io_q      <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      num_q     <= num_d;
      io_q      <= io_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (data_sram_en && !is_conf)
      for (int k = 0; k < 4; k++)
        if (data_sram_we[k]) mem_q[ram_idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;

endmodule
